// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: raster timing defaults and helpers shared by the scan-out engine.
package vga_scanout_pkg;
  localparam int CNT_W        = 10;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);
  // Active window bounds, referenced to sync start, for the GPU's coordinate mapping.
  localparam int DEF_H_ACT_LO = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_ACT_LO = DEF_V_SYNC + DEF_V_BP;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (sync, back porch, active, front porch), counted from sync start.
module vga_axis_counter
  import vga_scanout_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_raw,
  output logic             active
);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(axis_total(SYNC, BP, ACTIVE, FP) - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACTIVE);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (en) r_count <= wrap ? '0 : r_count + 1'b1;
  assign count    = r_count;
  assign wrap     = r_count == LAST;
  assign sync_raw = r_count < SYNC_END;
  assign active   = r_count >= ACT_LO && r_count < ACT_HI;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing and scan-out; issues {h,v} to the GPU and drives syncs/RGB
// one pixel later so colour and syncs leave aligned.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [2:0]  display_data,
  output logic [19:0] display_addr,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  vga_rgb,
  output logic        frame_start
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  logic [3:0]       r_div;
  logic             r_tick, r_hsync, r_vsync;
  logic [2:0]       r_rgb;
  logic [CNT_W-1:0] w_h, w_v;
  logic             w_h_wrap, w_v_wrap, w_h_sync, w_v_sync, w_h_act, w_v_act;
  vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h (
    .sysclk(sysclk), .rst_n(rst_n), .en(r_tick), .count(w_h),
    .wrap(w_h_wrap), .sync_raw(w_h_sync), .active(w_h_act)
  );
  vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v (
    .sysclk(sysclk), .rst_n(rst_n), .en(r_tick & w_h_wrap), .count(w_v),
    .wrap(w_v_wrap), .sync_raw(w_v_sync), .active(w_v_act)
  );
  // Output stage samples the pixel being left, so RGB/syncs trail display_addr by one pixel.
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= 3'b000;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_tick <= r_div == DIV_LAST;
      if (r_tick) begin
        r_rgb   <= (w_h_act && w_v_act) ? display_data : 3'b000;
        r_hsync <= w_h_sync ? SYNC_POL : ~SYNC_POL;
        r_vsync <= w_v_sync ? SYNC_POL : ~SYNC_POL;
      end
    end
  assign display_addr = {w_h, w_v};
  assign pixel_tick   = r_tick;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign vga_rgb      = r_rgb;
  assign frame_start  = r_tick & w_h_wrap & w_v_wrap;
endmodule
